// File: rtl/conv_stream_if.sv
// Handshake bundle for conv_stream: frame start, coefficient load, pixel in, result out, status.
// Latency: none (plain signal bundle, no storage).
// Backpressure: in_ready is driven by the slave, out_ready by the master.
// Ports (master = producer/consumer side, slave = conv_stream):
//   start, coef_valid, coef_data, in_valid, in_data, out_ready : master -> slave
//   in_ready, out_valid, out_data, busy, done                  : slave -> master
interface conv_stream_if #(
  parameter int W = 16
);
  logic                start;
  logic                coef_valid;
  logic signed [W-1:0] coef_data;
  logic                in_valid;
  logic signed [W-1:0] in_data;
  logic                in_ready;
  logic                out_valid;
  logic signed [W-1:0] out_data;
  logic                out_ready;
  logic                busy;
  logic                done;

  modport master (
    output start, coef_valid, coef_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, coef_valid, coef_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/conv_stream.sv
// Streaming KxK valid-mode 2D convolution over an NxN signed fixed-point image.
// Latency: 1 cycle from acceptance of the window's bottom-right pixel to out_valid.
// Backpressure: a held result (out_valid && !out_ready) drops in_ready, stalling the pixel stream.
// Ports: clk, rst (sync, active-high); s (conv_stream_if.slave) carries start, the
//   coefficient load (coef_valid/coef_data), the pixel stream (in_valid/in_data/in_ready),
//   the result stream (out_valid/out_data/out_ready) and status (busy, done).
module conv_stream #(
  parameter int N = 10,
  parameter int K = 5,
  parameter int W = 16,
  parameter int F = 10
) (
  input  logic         clk,
  input  logic         rst,
  conv_stream_if.slave s
);

  localparam int KK    = K * K;
  localparam int NN    = N * N;
  localparam int CW    = $clog2(N);
  localparam int KW    = $clog2(KK);
  localparam int PW    = $clog2(NN + 1);
  localparam int PRW   = 2 * W;
  localparam int ACC_W = 2 * W + $clog2(KK);

  localparam logic [KW-1:0] COEF_LAST = KW'(KK - 1);
  localparam logic [PW-1:0] PIX_TOTAL = PW'(NN);
  localparam logic [CW-1:0] COL_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] EDGE      = CW'(K - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - W + 1){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [KW-1:0] coef_cnt;
  logic [PW-1:0] pix_cnt;
  logic [CW-1:0] row;
  logic [CW-1:0] col;

  logic                out_valid_q;
  logic signed [W-1:0] out_data_q;
  logic                done_q;

  logic busy_c;
  logic pix_ready;
  logic pix_accept;
  logic coef_accept;
  logic last_hs;
  logic win_hit;

  // Storage that never needs clearing: the counters gate what reaches out_data.
  logic signed [W-1:0] coef   [KK];
  logic signed [W-1:0] lb     [K-1][N];
  logic signed [W-1:0] win    [K][K];
  logic signed [W-1:0] win_nx [K][K];

  logic signed [PRW-1:0]   prod [KK];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] scaled;
  logic signed [W-1:0]     sat_res;

  assign coef_accept = (state == LOAD) && s.coef_valid;
  assign pix_accept  = s.in_valid && pix_ready;
  // Only the last pixel can leave pix_cnt at NN with a result pending, so this is the final output.
  assign last_hs     = (pix_cnt == PIX_TOTAL) && out_valid_q && s.out_ready;
  assign win_hit     = (row >= EDGE) && (col >= EDGE);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (s.start) state_nx = LOAD;
      LOAD:    if (s.coef_valid && (coef_cnt == COEF_LAST)) state_nx = STREAM;
      STREAM:  if (last_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_c    = (state != IDLE);
    pix_ready = (state == STREAM) && (pix_cnt < PIX_TOTAL) && (!out_valid_q || s.out_ready);
  end

  // ---------------- counters and result register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_cnt    <= '0;
      pix_cnt     <= '0;
      row         <= '0;
      col         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state == STREAM) && last_hs;

      if ((state == IDLE) && s.start) begin
        coef_cnt <= '0;
        pix_cnt  <= '0;
        row      <= '0;
        col      <= '0;
      end

      if (coef_accept) coef_cnt <= coef_cnt + KW'(1);

      if (pix_accept) begin
        pix_cnt <= pix_cnt + PW'(1);
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      // pix_ready implies the old result is gone or leaving, so loading never drops one.
      if (pix_accept && win_hit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sat_res;
      end else if (s.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // ---------------- coefficient, line buffer and window storage ----------------
  // lb[0] holds row r-K+1 (oldest), lb[K-2] holds row r-1, all indexed by column.
  always_ff @(posedge clk) begin
    if (coef_accept) coef[coef_cnt] <= s.coef_data;
    if (pix_accept) begin
      win <= win_nx;
      for (int i = 0; i < K - 2; i++) lb[i][col] <= lb[i+1][col];
      lb[K-2][col] <= s.in_data;
    end
  end

  // Window after shifting in the column that the incoming pixel completes.
  always_comb begin
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K - 1; j++)
        win_nx[i][j] = win[i][j+1];
    for (int i = 0; i < K - 1; i++)
      win_nx[i][K-1] = lb[i][col];
    win_nx[K-1][K-1] = s.in_data;
  end

  // ---------------- multiply-accumulate, scale, saturate ----------------
  always_comb begin
    acc = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        prod[i*K+j] = PRW'(win_nx[i][j]) * PRW'(coef[i*K+j]);
        acc         = acc + ACC_W'(prod[i*K+j]);
      end
    end
    scaled = acc >>> F;  // floor rounding
    if (scaled > SAT_MAX)      sat_res = SAT_MAX[W-1:0];
    else if (scaled < SAT_MIN) sat_res = SAT_MIN[W-1:0];
    else                       sat_res = scaled[W-1:0];
  end

  assign s.in_ready  = pix_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.busy      = busy_c;
  assign s.done      = done_q;

endmodule

// File: tb/tb_conv_stream.sv
// Bench for conv_stream: two instances (10x10/5x5 and 7x7/3x3) sharing one driver via sel.
// Expected outputs come from a direct sum-of-products model over whole image arrays.
module tb_conv_stream;
  localparam int W = 16;
  localparam int F = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_stream_if #(.W(W)) bus_a ();
  conv_stream_if #(.W(W)) bus_b ();

  conv_stream #(.N(10), .K(5), .W(W), .F(F)) dut_a (.clk(clk), .rst(rst), .s(bus_a));
  conv_stream #(.N(7),  .K(3), .W(W), .F(F)) dut_b (.clk(clk), .rst(rst), .s(bus_b));

  // shared driver, steered to one instance
  logic                sel = 1'b0;
  logic                start = 1'b0, coef_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [W-1:0] coef_data = '0, in_data = '0;

  assign bus_a.start      = !sel && start;
  assign bus_a.coef_valid = !sel && coef_valid;
  assign bus_a.in_valid   = !sel && in_valid;
  assign bus_a.coef_data  = coef_data;
  assign bus_a.in_data    = in_data;
  assign bus_a.out_ready  = out_ready;
  assign bus_b.start      = sel && start;
  assign bus_b.coef_valid = sel && coef_valid;
  assign bus_b.in_valid   = sel && in_valid;
  assign bus_b.coef_data  = coef_data;
  assign bus_b.in_data    = in_data;
  assign bus_b.out_ready  = out_ready;

  logic         m_in_ready, m_out_valid, m_busy, m_done;
  logic [W-1:0] m_out_data;
  assign m_in_ready  = sel ? bus_b.in_ready  : bus_a.in_ready;
  assign m_out_valid = sel ? bus_b.out_valid : bus_a.out_valid;
  assign m_out_data  = sel ? bus_b.out_data  : bus_a.out_data;
  assign m_busy      = sel ? bus_b.busy      : bus_a.busy;
  assign m_done      = sel ? bus_b.done      : bus_a.done;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic signed [W-1:0] img [100];
  logic signed [W-1:0] cf  [25];

  function automatic logic [W-1:0] ref_pix(input int n, input int k, input int orow, input int ocol);
    longint acc = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        acc += longint'(img[(orow+i)*n + ocol + j]) * longint'(cf[i*k + j]);
    acc = acc >>> F;
    if (acc > 32767)  return 16'h7FFF;
    if (acc < -32768) return 16'h8000;
    return acc[W-1:0];
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] exp_q [$];
  int           out_cnt = 0, exp_total = 0, done_cnt = 0, stall_seen = 0, frames_done = 0;
  logic         prev_stall = 1'b0, prev_rst = 1'b1, prev_last = 1'b0;
  logic [W-1:0] prev_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_out_valid === 1'b1 && !out_ready) begin
        check("stall_in_ready", m_in_ready, 0);
        stall_seen++;
      end
      if (prev_stall && !prev_rst) begin
        check("hold_valid", m_out_valid, 1);
        check("hold_data", m_out_data, prev_data);
      end
      if (m_done === 1'b1 || prev_last) begin
        check("done_pulse", m_done, prev_last);
        if (m_done === 1'b1) done_cnt++;
      end
      prev_last = 1'b0;
      if (m_out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", m_out_data, 32'hFFFF_FFFF);
        end else begin
          check("out_data", m_out_data, exp_q.pop_front());
        end
        out_cnt++;
        prev_last = (out_cnt == exp_total);
      end
      prev_stall = (m_out_valid === 1'b1) && !out_ready;
      prev_data  = m_out_data;
      prev_rst   = rst;
    end
  end

  // ---------------- out_ready driver ----------------
  int or_mode = 0;    // 0 always ready, 1 random, 2 five-cycle stall after 3rd output
  int stall_left = 0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (or_mode == 0) out_ready = 1'b1;
      else if (or_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (out_cnt == 3 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else out_ready = 1'b1;
    end
  end

  // ---------------- frame driver ----------------
  // mode: 0 random, 1 coef 0x0080/pix 0x0400, 2 as 1 with pixel 3 = 0xA000,
  //       3 coef 0x0800, 4 coef 0xF800, 5 coef 0x0400 (pixels 0x0400 for 1..5)
  task automatic run_frame(input bit s_sel, input int n, input int k, input int mode,
                           input int rst_after, input bit chained);
    int  idx;
    int  guard;
    bit  rnd;
    bit  seen;
    rnd = (mode == 0);
    sel = s_sel;
    for (int i = 0; i < n*n; i++) img[i] = rnd ? W'($urandom) : 16'sh0400;
    if (mode == 2) img[3] = 16'shA000;
    for (int i = 0; i < k*k; i++) begin
      case (mode)
        0:       cf[i] = W'($urandom_range(0, 511) - 256);
        3:       cf[i] = 16'sh0800;
        4:       cf[i] = 16'shF800;
        5:       cf[i] = 16'sh0400;
        default: cf[i] = 16'sh0080;
      endcase
    end
    exp_q.delete();
    out_cnt    = 0;
    stall_seen = 0;
    exp_total  = (n-k+1) * (n-k+1);
    for (int r = 0; r <= n-k; r++)
      for (int c = 0; c <= n-k; c++)
        exp_q.push_back(ref_pix(n, k, r, c));

    if (!chained) begin
      @(posedge clk);
      #3;
    end
    start = 1'b1;
    @(posedge clk);
    #3;
    start = 1'b0;
    check("busy_after_start", m_busy, 1);

    idx = 0;
    while (idx < k*k) begin
      coef_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      coef_data  = cf[idx];
      @(negedge clk);
      if (coef_valid) idx++;
      @(posedge clk);
      #3;
    end
    coef_valid = 1'b0;

    idx = 0;
    guard = 0;
    while (idx < n*n) begin
      if (rst_after > 0 && idx == rst_after) begin
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        check("rst_busy", m_busy, 0);
        check("rst_out_valid", m_out_valid, 0);
        check("rst_in_ready", m_in_ready, 0);
        check("rst_done", m_done, 0);
        check("rst_out_data", m_out_data, 0);
        exp_q.delete();
        return;
      end
      in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = img[idx];
      @(negedge clk);
      if (in_valid && m_in_ready) idx++;
      guard++;
      if (guard > 5000) begin
        check("pixel_timeout", idx, n*n);
        break;
      end
      @(posedge clk);
      #3;
    end
    in_valid = 1'b0;

    seen = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      @(negedge clk);
      if (m_done) seen = 1'b1;
    end
    #1;
    check("done_seen", seen, 1);
    if (seen) frames_done++;
    check("out_count", out_cnt, exp_total);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3;
    check("reset_busy", m_busy, 0);
    check("reset_in_ready", m_in_ready, 0);
    check("reset_out_valid", m_out_valid, 0);
    check("reset_done", m_done, 0);
    check("reset_out_data", m_out_data, 0);
    rst = 1'b0;

    run_frame(1'b0, 10, 5, 1, 0, 1'b0);   // uniform 0x0C80
    run_frame(1'b0, 10, 5, 2, 0, 1'b1);   // started on the done cycle; first row cancels
    run_frame(1'b0, 10, 5, 3, 0, 1'b0);   // saturate high
    run_frame(1'b0, 10, 5, 4, 0, 1'b0);   // saturate low

    stall_left = 5;
    or_mode    = 2;
    run_frame(1'b0, 10, 5, 1, 0, 1'b0);
    check("stall_cycles", stall_seen, 5);
    or_mode = 0;

    run_frame(1'b0, 10, 5, 1, 50, 1'b0);  // reset mid-stream
    run_frame(1'b0, 10, 5, 1, 0, 1'b0);

    or_mode = 1;
    for (int f = 0; f < 4; f++) run_frame(1'b0, 10, 5, 0, 0, 1'b0);
    or_mode = 0;

    run_frame(1'b1, 7, 3, 5, 0, 1'b0);    // 25 outputs of 0x2400
    or_mode = 1;
    run_frame(1'b1, 7, 3, 0, 0, 1'b0);
    or_mode = 0;

    repeat (3) @(posedge clk);
    #3;
    check("done_total", done_cnt, frames_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_stream.md
CONV_STREAM -- requirements
Module: conv_stream

Interface
REQ-001 SHALL have parameter N, default 10, meaning square input image side in pixels (N >= K).
REQ-002 SHALL have parameter K, default 5, meaning square kernel side (K >= 2).
REQ-003 SHALL have parameter W, default 16, meaning signed fixed-point sample width.
REQ-004 SHALL have parameter F, default 10, meaning fractional bits (Q(W-F).F; 0x0400 = 1.0 at defaults).
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle pulse beginning a frame (coefficient load, then image).
REQ-008 SHALL have port coef_valid  input  1  coefficient present on coef_data.
REQ-009 SHALL have port coef_data  input  W  signed coefficient, row-major order.
REQ-010 SHALL have port in_valid  input  1  pixel present on in_data.
REQ-011 SHALL have port in_data  input  W  signed pixel, raster order.
REQ-012 SHALL have port in_ready  output  1  block accepts pixel this cycle.
REQ-013 SHALL have port out_valid  output  1  out_data holds a convolved pixel.
REQ-014 SHALL have port out_data  output  W  signed result, raster order, (N-K+1)^2 per frame.
REQ-015 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse after last output handshake of a frame.

Function
REQ-018 SHALL implement states IDLE, LOAD, STREAM; IDLE->LOAD on start; LOAD->STREAM when the K*K-th coefficient is accepted; STREAM->IDLE on handshake of the last output, with done asserted the following cycle.
REQ-019 SHALL ignore start outside IDLE, coef_valid outside LOAD, and treat in_valid as unaccepted outside STREAM.
REQ-020 SHALL accept a coefficient on every LOAD cycle where coef_valid=1, storing it at index coef_count (0..K*K-1, row-major).
REQ-021 SHALL drive in_ready = (state==STREAM) && (pixel_count < N*N) && (!out_valid || out_ready).
REQ-022 SHALL accept a pixel when in_valid && in_ready, storing it in K-1 line buffers plus a KxK window register and tracking row r and column c (wrap c at N-1 to 0, increment r).
REQ-023 SHALL, when the accepted pixel is at (r,c) with r>=K-1 and c>=K-1, compute sum over i,j of window(i,j)*coef(i,j), window(i,j) = pixel(r-K+1+i, c-K+1+j), and register the result with out_valid=1 on the next cycle (latency 1).
REQ-024 SHALL form full products of 2W bits and accumulate in 2W+ceil(log2(K*K)) bits with no intermediate truncation.
REQ-025 SHALL scale the sum by arithmetic right shift of F bits (floor rounding), then saturate to [-2^(W-1), 2^(W-1)-1].
REQ-026 SHALL hold out_valid and out_data stable while out_valid && !out_ready; out_valid clears after handshake unless a new result is loaded that same cycle.
REQ-027 SHALL produce no output for accepted pixels with r<K-1 or c<K-1 (valid-mode convolution, no padding).
REQ-028 SHALL allow back-to-back frames: a start in the cycle done is high begins LOAD and requires a full coefficient reload.

Reset
REQ-029 SHALL on rst=1 at a clock edge set state=IDLE, out_valid=0, out_data=0, done=0, busy=0, in_ready=0, and all counters (coef, pixel, row, column) to 0, taking priority over every other input, including mid-LOAD and mid-STREAM.
REQ-030 SHALL not require line-buffer, window, or coefficient storage to be cleared by reset; stale contents never reach out_data because the counters restart.

Verification
REQ-031 SHALL pass: defaults, all 25 coefs 0x0080, all 100 pixels 0x0400, out_ready=1 -> 36 outputs, all 0x0C80, done pulses once.
REQ-032 SHALL pass: as REQ-031 but pixel index 3 = 0xA000 -> outputs 0..3 are 0x0000, outputs 4..35 are 0x0C80.
REQ-033 SHALL pass: coefs 0x0800, pixels 0x0400 -> all 36 outputs 0x7FFF; coefs 0xF800 -> all 36 outputs 0x8000.
REQ-034 SHALL pass: REQ-031 with out_ready low for 5 cycles after the 3rd output -> in_ready low during the stall, out_data held, still exactly 36 outputs of 0x0C80 in order.
REQ-035 SHALL pass: rst pulsed after 50 pixels in STREAM -> next cycle busy=0, out_valid=0, in_ready=0; a new start plus full reload yields the REQ-031 result.
REQ-036 SHALL pass: N=7, K=3, coefs 0x0400, pixels 0x0400 -> 25 outputs, all 0x2400, done pulses once.
